// File: rtl/rx_frontend_iq.sv
// rtl/rx_frontend_iq.sv - ADC I/Q receive frontend: channel mux, DC removal, IQ balance
module rx_frontend_iq #(
    parameter int BASE      = 0,
    parameter int WIDTH_IN  = 16,
    parameter int IQCOMP_EN = 1,
    parameter int DC_SHIFT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_stb,
    input  logic [7:0]          set_addr,
    input  logic [31:0]         set_data,
    input  logic                run,
    input  logic [WIDTH_IN-1:0] adc_a,
    input  logic [WIDTH_IN-1:0] adc_b,
    output logic [23:0]         rx_i,
    output logic [23:0]         rx_q
);
    localparam int IW = 24 + DC_SHIFT;
    localparam logic [7:0] A_MUX   = 8'(BASE);
    localparam logic [7:0] A_DCI   = 8'(BASE + 1);
    localparam logic [7:0] A_DCQ   = 8'(BASE + 2);
    localparam logic [7:0] A_MAG   = 8'(BASE + 3);
    localparam logic [7:0] A_PHASE = 8'(BASE + 4);
    localparam logic [7:0] A_TEST  = 8'(BASE + 5);
    localparam logic [IW-1:0] INTEG_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic [IW-1:0] INTEG_MIN = {1'b1, {(IW-1){1'b0}}};

    function automatic logic [23:0] clip24(input logic [24:0] v);
        if (v[24] != v[23]) return v[24] ? 24'h800000 : 24'h7fffff;
        return v[23:0];
    endfunction

    // Negating the most negative value would wrap back onto itself, so it clips to max
    function automatic logic [23:0] neg_clip(input logic [23:0] v);
        return (v == 24'h800000) ? 24'h7fffff : -v;
    endfunction

    // Integrator accumulate with clamping at its own range, never wrapping
    function automatic logic [IW-1:0] integ_step(input logic [IW-1:0] acc, input logic [24:0] err);
        logic [IW:0] sum;
        sum = {acc[IW-1], acc} + (IW+1)'($signed(err));
        if (sum[IW] != sum[IW-1]) return sum[IW] ? INTEG_MIN : INTEG_MAX;
        return sum[IW-1:0];
    endfunction

    logic [2:0]    mux_r;
    logic [7:0]    test_r;
    logic [17:0]   mag_r, phase_r;
    logic          freeze_i, freeze_q;
    logic [IW-1:0] integ_i, integ_q;
    logic [23:0]   s1_i, s1_q, dc_i, dc_q;
    logic [23:0]   ext_a, ext_b, sel_i, sel_q, est_i, est_q;
    logic [24:0]   err_i, err_q;
    logic [IW-1:0] ld_val;
    logic          wr_dci, wr_dcq, frz_i, frz_q;
    logic          unused_set;

    assign unused_set = ^set_data[29:24];

    assign ext_a = 24'(adc_a) << (24 - WIDTH_IN);
    assign ext_b = 24'(adc_b) << (24 - WIDTH_IN);
    assign sel_i = mux_r[0] ? ext_b : ext_a;
    assign sel_q = mux_r[0] ? ext_a : ext_b;

    assign est_i = integ_i[IW-1:DC_SHIFT];
    assign est_q = integ_q[IW-1:DC_SHIFT];
    assign err_i = {s1_i[23], s1_i} - {est_i[23], est_i};
    assign err_q = {s1_q[23], s1_q} - {est_q[23], est_q};

    // A DC write's freeze bit already governs adaptation on the cycle of the write itself
    assign wr_dci = set_stb && (set_addr == A_DCI);
    assign wr_dcq = set_stb && (set_addr == A_DCQ);
    assign frz_i  = wr_dci ? set_data[30] : freeze_i;
    assign frz_q  = wr_dcq ? set_data[30] : freeze_q;
    assign ld_val = IW'(set_data[23:0]) << DC_SHIFT;

    // Setting-bus registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_r    <= '0;
            test_r   <= '0;
            mag_r    <= '0;
            phase_r  <= '0;
            freeze_i <= 1'b0;
            freeze_q <= 1'b0;
        end else if (set_stb) begin
            case (set_addr)
                A_MUX:   mux_r    <= set_data[2:0];
                A_DCI:   freeze_i <= set_data[30];
                A_DCQ:   freeze_q <= set_data[30];
                A_MAG:   mag_r    <= set_data[17:0];
                A_PHASE: phase_r  <= set_data[17:0];
                A_TEST:  test_r   <= set_data[7:0];
                default: ;
            endcase
        end
    end

    // DC integrators: load wins over adaptation and freeze; run low simply holds
    always_ff @(posedge clk) begin
        if (rst) begin
            integ_i <= '0;
            integ_q <= '0;
        end else begin
            if (wr_dci && set_data[31])  integ_i <= ld_val;
            else if (run && !frz_i)      integ_i <= integ_step(integ_i, err_i);
            if (wr_dcq && set_data[31])  integ_q <= ld_val;
            else if (run && !frz_q)      integ_q <= integ_step(integ_q, err_q);
        end
    end

    // S1: channel select/swap, left-justify, optional clipped inversion
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_i <= '0;
            s1_q <= '0;
        end else begin
            s1_i <= mux_r[1] ? neg_clip(sel_i) : sel_i;
            s1_q <= mux_r[2] ? neg_clip(sel_q) : sel_q;
        end
    end

    // S2: DC-corrected sample, raw S1 sample in bypass, zero for any other test value
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_i <= '0;
            dc_q <= '0;
        end else begin
            case (test_r)
                8'd0: begin
                    dc_i <= clip24(err_i);
                    dc_q <= clip24(err_q);
                end
                8'd1: begin
                    dc_i <= s1_i;
                    dc_q <= s1_q;
                end
                default: begin
                    dc_i <= '0;
                    dc_q <= '0;
                end
            endcase
        end
    end

    if (IQCOMP_EN != 0) begin : g_iq
        logic [23:0]        dly_i, dly_q;
        logic signed [35:0] prod_i, prod_q;
        logic               unused_iq;

        assign unused_iq = ^{prod_i[11:0], prod_q[11:0]};

        // S3: balance products from the I branch; zero in test modes so bypass stays raw
        always_ff @(posedge clk) begin
            if (rst) begin
                dly_i  <= '0;
                dly_q  <= '0;
                prod_i <= '0;
                prod_q <= '0;
            end else begin
                dly_i <= dc_i;
                dly_q <= dc_q;
                if (test_r == 8'd0) begin
                    prod_i <= $signed(dc_i[23:6]) * $signed(mag_r);
                    prod_q <= $signed(dc_i[23:6]) * $signed(phase_r);
                end else begin
                    prod_i <= '0;
                    prod_q <= '0;
                end
            end
        end

        // S4: add scaled correction terms with clipping
        always_ff @(posedge clk) begin
            if (rst) begin
                rx_i <= '0;
                rx_q <= '0;
            end else begin
                rx_i <= clip24({dly_i[23], dly_i} + {prod_i[35], prod_i[35:12]});
                rx_q <= clip24({dly_q[23], dly_q} + {prod_q[35], prod_q[35:12]});
            end
        end
    end else begin : g_no_iq
        logic unused_iq;

        assign unused_iq = ^{mag_r, phase_r};
        assign rx_i = dc_i;
        assign rx_q = dc_q;
    end
endmodule

// File: doc/rx_frontend_iq.md
Name: rx_frontend_iq

Overview:
Receive-side counterpart of the TX frontend. It takes the raw ADC I/Q pair and applies channel mux/swap/invert, sign-extension to 24 bits and adaptive DC-offset removal. It then applies IQ magnitude/phase balance and delivers 24-bit rx_i/rx_q to the DDC. All controls come from setting-bus registers at BASE+0..BASE+5.

Parameters:
BASE, 0, setting-bus base address
WIDTH_IN, 16, ADC sample width (12 for the LMS6002D build)
IQCOMP_EN, 1, 1 = IQ balance stage instantiated; 0 = stage omitted
DC_SHIFT, 8, DC loop gain 2^-DC_SHIFT; integrator width 24+DC_SHIFT

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
set_stb  in  1  setting-bus strobe
set_addr  in  8  setting-bus address
set_data  in  32  setting-bus data
run  in  1  receive active; DC loop adapts only while high
adc_a  in  WIDTH_IN  ADC channel A, two's complement
adc_b  in  WIDTH_IN  ADC channel B, two's complement
rx_i  out  24  corrected I, two's complement
rx_q  out  24  corrected Q, two's complement

Behaviour:
- Reset: every pipeline register, integrator, setting and output is 0. rx_i = rx_q = 0 from the cycle after rst is sampled high.
- Settings:
  - BASE+0 mux (8b): bit0 swap (I=adc_b, Q=adc_a); bit1 invert I; bit2 invert Q.
  - BASE+1 / BASE+2 DC I / DC Q (32b): bit31 load, bit30 freeze, [23:0] load value.
  - BASE+3 mag_corr (18b signed).
  - BASE+4 phase_corr (18b signed).
  - BASE+5 test (8b): 0 = normal; 1 = bypass DC and IQ stages; other values force outputs to 0.
- S1, registered: select/swap. Then sign-extend and left-justify each channel: x = {adc, (24-WIDTH_IN) zeros}. Invert = two's-complement negate with clip, so -2^23 becomes 2^23-1.
- S2 DC, registered:
  - est = integ[23+DC_SHIFT:DC_SHIFT].
  - err = x - est, 25-bit.
  - Output is clip24(err).
  - integ <= sat(integ + sext(err)) when run=1, freeze=0 and no load that cycle; otherwise integ holds.
  - Saturation clamps at the integrator's max/min and never wraps.
- Load: a write to BASE+1/2 with bit31=1 sets integ <= {value, DC_SHIFT zeros} on the cycle after the strobe. Load takes priority over adaptation and over freeze in that cycle. Freeze state applies from the same write onward. Writing with bit31=0 changes only freeze.
- run low: integrator holds its value (not cleared); samples keep flowing.
- S3/S4, IQCOMP_EN=1:
  - S3 registers the 18x18 signed products pi = dc_i[23:6]*mag_corr and pq = dc_i[23:6]*phase_corr, and delays dc_i/dc_q by one cycle.
  - S4 computes rx_i = clip24(dc_i + pi[35:12]) and rx_q = clip24(dc_q + pq[35:12]), registered.
- Latency from adc_* to rx_*: 4 cycles with IQCOMP_EN=1, 2 cycles with IQCOMP_EN=0. Bypass (test=1) outputs the S1 value with the same latency. Switching test mode produces no extra bubbles.
- Setting writes take effect on the sample in S1/S2/S3 at the cycle following the strobe. No glitch-free handoff is guaranteed on the sample in flight.
- Reset mid-operation: the next cycle clears integrators and settings. Output is 0 until fresh samples propagate through the full latency.

Test Plan:
1. Latency, freeze: write BASE+1 and BASE+2 = 0x40000000 (freeze, est 0); adc_a=0x1000, adc_b=0xF000, run=1 -> rx_i=0x100000, rx_q=0xF00000 exactly 4 cycles after the input change.
2. DC convergence: defaults, run=1, adc_a constant 0x1000 -> rx_i starts at 0x100000 and decays monotonically; |rx_i| <= 2 after 4096 cycles. Drop run to 0 -> integ frozen, rx_i stable.
3. Load: write BASE+1 = 0xC0100000 with adc_a=0x1000 -> rx_i = 0 from the cycle (strobe+1+latency) onward. With run=1 it stays 0 and the integrator does not move.
4. Swap/invert/clip: BASE+0 = 0x03, adc_b=0x8000, frozen DC 0 -> rx_i = 0x7FFFFF (clipped negation of 0x800000); rx_q follows adc_a.
5. IQ balance: frozen DC 0, adc_a=0x1000, adc_b=0, mag_corr=0x00800, phase_corr=0x3F800 -> rx_i=0x102000, rx_q=0xFFE000.
6. Test mux and reset: BASE+5=1 with corrections set -> rx_i/rx_q equal the raw extended inputs. BASE+5=2 -> both outputs 0. Assert rst for 1 cycle mid-stream -> all settings read back as defaults and outputs are 0 on the next cycle.
